// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared types and light encodings for the pedestrian signal controller
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WALK  = 2'd2,
    FLASH = 2'd3
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  function automatic logic light_valid(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

endpackage

// File: rtl/ped_flash_timer.sv
// rtl/ped_flash_timer.sv - FLASH_PERIOD divider; strobe marks a dont_walk toggle point
module ped_flash_timer #(
  parameter int FLASH_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic strobe
);

  logic [7:0] div;

  assign strobe = (div == 8'(FLASH_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div <= '0;
    end else if (strobe) begin
      div <= '0;
    end else begin
      div <= div + 8'd1;
    end
  end

endmodule

// File: rtl/ped_signal_controller.sv
// rtl/ped_signal_controller.sv - pedestrian walk/flash sequencer locked to vehicle red
// Optional countdown output enabled by defining PED_COUNTDOWN_EN.
module ped_signal_controller
  import ped_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int FLASH_PERIOD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_wait
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [7:0] countdown
`endif
);

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       pending, pending_n;
  logic       prev_red;
  logic       walk_n, dont_walk_n, ped_wait_n;
  logic       is_red, red_start, flash_tgl;

  assign is_red    = (light == LIGHT_RED);
  assign red_start = is_red && !prev_red;

  ped_flash_timer #(.FLASH_PERIOD(FLASH_PERIOD)) u_flash_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != FLASH),
    .strobe (flash_tgl)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pending_n = pending;
    if (ped_btn) pending_n = 1'b1;

    // A corrupt light input is treated as unsafe: drop to IDLE but keep the request.
    if (!light_valid(light)) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ped_btn || pending) state_n = ARMED;
        end
        ARMED: begin
          if (red_start) begin
            state_n   = WALK;
            cnt_n     = WALK_LOAD;
            pending_n = 1'b0;
          end
        end
        WALK: begin
          if (!is_red) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == 8'd0) begin
            state_n = FLASH;
            cnt_n   = FLASH_LOAD;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        FLASH: begin
          if (!is_red || cnt == 8'd0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    walk_n = (state_n == WALK);
    if (state_n == FLASH) begin
      dont_walk_n = (state == FLASH) ? (dont_walk ^ flash_tgl) : 1'b1;
    end else begin
      dont_walk_n = (state_n != WALK);
    end
    ped_wait_n = (state_n == ARMED) || pending_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      prev_red  <= 1'b1;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      ped_wait  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      prev_red  <= is_red;
      walk      <= walk_n;
      dont_walk <= dont_walk_n;
      ped_wait  <= ped_wait_n;
    end
  end

`ifdef PED_COUNTDOWN_EN
  assign countdown = (state == FLASH) ? cnt : 8'd0;
`endif

endmodule

// File: tb/tb_ped_signal_controller.sv
// tb/tb_ped_signal_controller.sv - scoreboard bench for ped_signal_controller
module tb_ped_signal_controller;
  import ped_pkg::*;

`ifdef PED_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  typedef struct packed {
    logic        rs;
    logic [2:0]  lt;
    logic        bt;
    logic [10:0] ex;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light = LIGHT_GREEN;
  logic       ped_btn = 1'b0;
  logic       walk, dont_walk, ped_wait;
  logic [7:0] cd_obs;

  stim_t       stim[$];
  logic [10:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown;
  assign cd_obs = countdown;
  ped_signal_controller dut (
    .clk(clk), .rst(rst), .light(light), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .ped_wait(ped_wait), .countdown(countdown)
  );
`else
  assign cd_obs = 8'd0;
  ped_signal_controller dut (
    .clk(clk), .rst(rst), .light(light), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .ped_wait(ped_wait)
  );
`endif

  task automatic add(input logic rs, input logic [2:0] lt, input logic bt,
                     input logic w, input logic dw, input logic pw, input int cd);
    stim_t s;
    s.rs = rs;
    s.lt = lt;
    s.bt = bt;
    s.ex = {w, dw, pw, (CD_EN ? 8'(cd) : 8'd0)};
    stim.push_back(s);
  endtask

  task automatic test_reset();
    stim_t s; logic [10:0] e; int i = 0;
    add(1, LIGHT_GREEN, 0, 0, 1, 0, 0);
    add(1, LIGHT_GREEN, 1, 0, 1, 0, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL reset[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  task automatic test_walk_cycle();
    stim_t s; logic [10:0] e; int i = 0;
    add(0, LIGHT_GREEN, 1, 0, 1, 1, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) add(0, LIGHT_RED, 0, 0, ((k / 2) % 2) == 0, 0, 5 - k);
    add(0, LIGHT_RED, 0, 0, 1, 0, 0);
    add(0, LIGHT_RED, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL walk_cycle[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  task automatic test_red_active_abort();
    stim_t s; logic [10:0] e; int i = 0;
    add(0, LIGHT_RED, 1, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 0, 1, 1, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    add(0, LIGHT_YELLOW, 0, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 0, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL red_active_abort[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  task automatic test_invalid_light();
    stim_t s; logic [10:0] e; int i = 0;
    add(0, LIGHT_GREEN, 1, 0, 1, 1, 0);
    add(0, 3'b101, 0, 0, 1, 1, 0);
    add(0, 3'b000, 0, 0, 1, 1, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL invalid_light[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  task automatic test_pending_in_walk();
    stim_t s; logic [10:0] e; int i = 0;
    add(0, LIGHT_GREEN, 1, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_RED, 1, 1, 0, 1, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL pending_in_walk[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; logic [10:0] e; int i = 0;
    add(0, LIGHT_GREEN, 1, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_RED, 1, 0, 1, 1, 5);
    add(0, LIGHT_RED, 0, 0, 1, 1, 4);
    add(0, LIGHT_RED, 0, 0, 0, 1, 3);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_GREEN, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_walk();
    stim_t s; logic [10:0] e; int i = 0;
    add(0, LIGHT_GREEN, 1, 0, 1, 1, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(0, LIGHT_RED, 0, 1, 0, 0, 0);
    add(1, LIGHT_RED, 0, 0, 1, 0, 0);
    add(0, LIGHT_RED, 0, 0, 1, 0, 0);
    add(0, LIGHT_RED, 0, 0, 1, 0, 0);
    while (stim.size() > 0) begin
      s = stim.pop_front();
      rst = s.rs; light = s.lt; ped_btn = s.bt; sb.push_back(s.ex);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({walk, dont_walk, ped_wait, cd_obs} !== e) begin
        errors++;
        $display("FAIL reset_mid_walk[%0d] got w,dw,pw,cd=%b exp=%b", i, {walk, dont_walk, ped_wait, cd_obs}, e);
      end
      i++;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_walk_cycle();
    test_red_active_abort();
    test_invalid_light();
    test_pending_in_walk();
    test_back_to_back();
    test_reset_mid_walk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
